// File: rtl/uart_tx_engine.sv
// uart_tx_engine: parametrised UART transmitter with runtime parity, 1/2 stop bits and per-frame prescale
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP_2} state_t;
  state_t state;
  logic [PRESCALE_W-1:0] pre_q, pcnt;
  logic [BW-1:0] bcnt;
  logic [DATA_WIDTH-1:0] sh;
  logic par_en_q, par_bit, stop2_q, adv;
  // bit advance when the prescale counter reaches the last cycle of the bit
  always_comb adv = pcnt == pre_q - PRESCALE_W'(1);
  // frame FSM: latches the word and settings on acceptance, then serialises with registered outputs
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      pre_q <= '0;
      pcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      par_en_q <= 1'b0;
      par_bit <= 1'b0;
      stop2_q <= 1'b0;
      TX_OUT <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      pcnt <= '0;
      bcnt <= '0;
      if (Data_Valid) begin
        state <= START;
        TX_OUT <= 1'b0;
        busy <= 1'b1;
        sh <= P_DATA;
        par_en_q <= PAR_EN;
        par_bit <= ^P_DATA ^ PAR_TYP;
        stop2_q <= STOP2;
        pre_q <= PRESCALE == '0 ? PRESCALE_W'(1) : PRESCALE;
      end
    end else if (!adv) begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end else begin
      pcnt <= '0;
      case (state)
        START: begin
          state <= DATA;
          TX_OUT <= sh[0];
          sh <= sh >> 1;
        end
        DATA: begin
          if (bcnt == BW'(DATA_WIDTH - 1)) begin
            state <= par_en_q ? PARITY : STOP;
            TX_OUT <= par_en_q ? par_bit : 1'b1;
          end else begin
            bcnt <= bcnt + BW'(1);
            TX_OUT <= sh[0];
            sh <= sh >> 1;
          end
        end
        PARITY: begin
          state <= STOP;
          TX_OUT <= 1'b1;
        end
        STOP: begin
          state <= stop2_q ? STOP_2 : IDLE;
          busy <= stop2_q;
          done <= !stop2_q;
          TX_OUT <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          TX_OUT <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed table-driven check of uart_tx_engine frames, ignores, back-to-back and reset
module tb_uart_tx_engine;
  logic CLK = 0, RST = 0, Data_Valid = 0, PAR_EN = 0, PAR_TYP = 0, STOP2 = 0;
  logic TX_OUT, busy, done;
  logic [7:0] P_DATA = '0;
  logic [15:0] PRESCALE = '0;
  int total = 0, bad = 0;
  typedef struct {
    logic [7:0] d;
    logic pe, pt, s2;
    logic [15:0] pre;
    int nb;
    logic [11:0] bits;
  } vec_t;
  vec_t vt[6];
  vec_t rv;
  uart_tx_engine #(.DATA_WIDTH(8), .PRESCALE_W(16)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .busy(busy), .done(done)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic go(input vec_t v);
    @(negedge CLK);
    P_DATA = v.d;
    PAR_EN = v.pe;
    PAR_TYP = v.pt;
    STOP2 = v.s2;
    PRESCALE = v.pre;
    Data_Valid = 1;
    @(negedge CLK);
    Data_Valid = 0;
  endtask
  task automatic frame(input int id, input vec_t v, input bit scr);
    int p;
    p = v.pre == 0 ? 1 : int'(v.pre);
    go(v);
    for (int k = 0; k < p * v.nb; k++) begin
      if (k > 0) @(negedge CLK);
      if (scr && k == 2) begin
        P_DATA = 8'hFF;
        PAR_TYP = ~v.pt;
        PAR_EN = ~v.pe;
        STOP2 = ~v.s2;
        PRESCALE = 16'd7;
        Data_Valid = 1;
      end
      if (scr && k == 3) Data_Valid = 0;
      chk($sformatf("v%0d tx c%0d", id, k), TX_OUT, v.bits[k/p]);
      chk($sformatf("v%0d busy c%0d", id, k), busy, 1);
      chk($sformatf("v%0d done_lo c%0d", id, k), done, 0);
    end
    @(negedge CLK);
    chk($sformatf("v%0d done", id), done, 1);
    chk($sformatf("v%0d busy_end", id), busy, 0);
    chk($sformatf("v%0d tx_end", id), TX_OUT, 1);
    @(negedge CLK);
    chk($sformatf("v%0d done_one", id), done, 0);
    chk($sformatf("v%0d idle_busy", id), busy, 0);
    chk($sformatf("v%0d idle_tx", id), TX_OUT, 1);
  endtask
  initial begin
    vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd1, 10, 12'b1111_0100_1010};
    vt[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 16'd4, 11, 12'b1101_0100_1010};
    vt[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 16'd2, 12, 12'b1110_0000_0000};
    vt[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 16'd0, 10, 12'b1110_0111_1000};
    vt[4] = '{8'hA5, 1'b1, 1'b1, 1'b1, 16'd3, 12, 12'b1111_0100_1010};
    vt[5] = '{8'h01, 1'b1, 1'b0, 1'b0, 16'd1, 11, 12'b1110_0000_0010};
    rv = '{8'h3C, 1'b0, 1'b0, 1'b0, 16'd2, 10, 12'b1110_0111_1000};
    #12;
    chk("rst tx", TX_OUT, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    @(negedge CLK);
    RST = 1;
    for (int i = 0; i < 6; i++) frame(i, vt[i], i % 2 == 1 || i == 2);
    @(negedge CLK);
    P_DATA = vt[0].d;
    PAR_EN = 0;
    PAR_TYP = 0;
    STOP2 = 0;
    PRESCALE = 16'd1;
    Data_Valid = 1;
    for (int k = 0; k < 22; k++) begin
      int j;
      j = k % 11;
      @(negedge CLK);
      chk($sformatf("b2b tx c%0d", k), TX_OUT, j == 10 ? 1'b1 : vt[0].bits[j]);
      chk($sformatf("b2b busy c%0d", k), busy, j != 10);
      chk($sformatf("b2b done c%0d", k), done, j == 10);
      if (k == 21) Data_Valid = 0;
    end
    @(negedge CLK);
    chk("b2b stop busy", busy, 0);
    chk("b2b stop tx", TX_OUT, 1);
    go(rv);
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_rst tx", TX_OUT, 0);
    chk("pre_rst busy", busy, 1);
    #2 RST = 0;
    #1;
    chk("async tx", TX_OUT, 1);
    chk("async busy", busy, 0);
    chk("async done", done, 0);
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    chk("post_rst tx", TX_OUT, 1);
    chk("post_rst busy", busy, 0);
    frame(9, rv, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
